router_ram_fifo_ctrl: RTL and testbench

//  Flow-control front end for the 4x73 vendor RAM macro in the router datapath.

---
 rtl/router_pkg.sv | 9 +
 rtl/router_skid_fifo.sv | 53 +++++
 rtl/router_ram_fifo_ctrl.sv | 93 +++++++++
 tb/tb_router_ram_fifo_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared sizes for the router RAM FIFO front end
package router_pkg;
    localparam int ROUTER_FLIT_W     = 73;
    localparam int ROUTER_RAM_AW     = 2;
    localparam int ROUTER_RAM_RD_LAT = 2;
    localparam int ROUTER_SKID_D     = 3;

    typedef logic [ROUTER_FLIT_W-1:0] router_flit_t;
endpackage

// File: rtl/router_skid_fifo.sv
// rtl/router_skid_fifo.sv - registered first-word-fall-through skid FIFO
module router_skid_fifo
    import router_pkg::*;
#(
    parameter  int DATA_W = ROUTER_FLIT_W,
    parameter  int DEPTH  = ROUTER_SKID_D,
    localparam int CW     = $clog2(DEPTH + 1),
    localparam int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_tvalid,
    input  logic [DATA_W-1:0] s_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic [CW-1:0]     count
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              push;
    logic              pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign push     = s_tvalid;
    assign pop      = m_tvalid && m_tready;
    assign m_tvalid = (count != '0);
    assign m_tdata  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= s_tdata;
    end

    // The producer has no ready; it must reserve space before issuing reads.
    overflow_chk: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && count == CW'(DEPTH)));
endmodule

// File: rtl/router_ram_fifo_ctrl.sv
// rtl/router_ram_fifo_ctrl.sv - stream-to-RAM FIFO controller hiding RAM read latency
module router_ram_fifo_ctrl
    import router_pkg::*;
#(
    parameter int DATA_W = ROUTER_FLIT_W,
    parameter int ADDR_W = ROUTER_RAM_AW,
    parameter int RD_LAT = ROUTER_RAM_RD_LAT,
    parameter int SKID_D = ROUTER_SKID_D,
    parameter int CNT_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic [CNT_W-1:0]  occ_count
);
    localparam int          DEPTH   = 2 ** ADDR_W;
    localparam int          RAM_CW  = ADDR_W + 1;
    localparam int          SKID_CW = $clog2(SKID_D + 1);
    localparam int unsigned SKID_DU = SKID_D;

    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0]  rd_ptr;
    logic [RAM_CW-1:0]  ram_cnt;
    logic [RD_LAT-1:0]  inflight;
    logic [SKID_CW-1:0] skid_cnt;
    int unsigned        inflight_cnt;
    logic               push;
    logic               pop;
    logic               rd_go;

    always_comb begin
        inflight_cnt = 0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight_cnt = inflight_cnt + 32'(inflight[i]);
        end
    end

    assign in_ready = (ram_cnt != RAM_CW'(DEPTH)) && !rst;
    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;

    // Issue a read only when the skid FIFO is guaranteed a free slot on return.
    assign rd_go = !rst && (ram_cnt != '0)
                 && ((32'(skid_cnt) + inflight_cnt - 32'(pop)) < SKID_DU);

    assign ram_wr_en   = push;
    assign ram_wr_addr = wr_ptr;
    assign ram_wr_data = in_data;
    assign ram_rd_en   = rd_go;
    assign ram_rd_addr = rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ram_cnt   <= '0;
            inflight  <= '0;
            occ_count <= '0;
        end else begin
            if (push)  wr_ptr <= wr_ptr + 1'b1;
            if (rd_go) rd_ptr <= rd_ptr + 1'b1;
            ram_cnt  <= ram_cnt + RAM_CW'(push) - RAM_CW'(rd_go);
            inflight <= (inflight << 1) | RD_LAT'(rd_go);
            // Words only enter by push and leave by pop, so this equals ram+inflight+skid.
            occ_count <= occ_count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    router_skid_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (SKID_D)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .s_tvalid (inflight[RD_LAT-1]),
        .s_tdata  (ram_rd_data),
        .m_tvalid (out_valid),
        .m_tready (out_ready),
        .m_tdata  (out_data),
        .count    (skid_cnt)
    );
endmodule

// File: tb/tb_router_ram_fifo_ctrl.sv
// tb/tb_router_ram_fifo_ctrl.sv - self-checking bench for router_ram_fifo_ctrl
module tb_router_ram_fifo_ctrl;
    import router_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    router_flit_t in_data;
    logic         out_valid;
    logic         out_ready;
    router_flit_t out_data;
    logic         ram_wr_en;
    logic [1:0]   ram_wr_addr;
    router_flit_t ram_wr_data;
    logic         ram_rd_en;
    logic [1:0]   ram_rd_addr;
    router_flit_t ram_rd_data;
    logic [2:0]   occ_count;

    always #5 clk = ~clk;

    router_ram_fifo_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .ram_wr_en   (ram_wr_en),
        .ram_wr_addr (ram_wr_addr),
        .ram_wr_data (ram_wr_data),
        .ram_rd_en   (ram_rd_en),
        .ram_rd_addr (ram_rd_addr),
        .ram_rd_data (ram_rd_data),
        .occ_count   (occ_count)
    );

    // 4-entry RAM with two-stage read pipeline; non-read cycles return a marker.
    router_flit_t ram_mem [4];
    router_flit_t rd_p1;
    always @(posedge clk) begin
        if (ram_wr_en) ram_mem[ram_wr_addr] <= ram_wr_data;
        rd_p1       <= ram_rd_en ? ram_mem[ram_rd_addr] : 73'h1_DEAD;
        ram_rd_data <= rd_p1;
    end

    typedef struct {
        logic         rst, iv;
        router_flit_t d;
        logic         ordy;
        logic         e_ir, e_wr;
        logic [1:0]   e_wa;
        logic         e_rd;
        logic [1:0]   e_ra;
        logic         e_ov;
        router_flit_t e_data;
        logic [2:0]   e_occ;
    } vec_t;

    vec_t         tbl [$];
    router_flit_t q [$];
    int           checks = 0;
    int           failures = 0;
    int           npop = 0;
    logic         stalled = 1'b0;
    router_flit_t held;

    function automatic vec_t mk(logic r, logic iv, router_flit_t d, logic ordy,
                                logic ir, logic wr, logic [1:0] wa, logic rd,
                                logic [1:0] ra, logic ov, router_flit_t dat,
                                logic [2:0] occ);
        vec_t v;
        v.rst = r; v.iv = iv; v.d = d; v.ordy = ordy; v.e_ir = ir; v.e_wr = wr;
        v.e_wa = wa; v.e_rd = rd; v.e_ra = ra; v.e_ov = ov; v.e_data = dat;
        v.e_occ = occ;
        return v;
    endfunction

    task automatic chk(input string name, input logic [72:0] act, input logic [72:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called mid-cycle: track accepted words, check pops, occupancy and stall stability.
    task automatic sb_cycle();
        router_flit_t e;
        if (rst) begin
            q.delete();
            stalled = 1'b0;
        end else begin
            chk("occ_vs_model", 73'(occ_count), 73'(q.size()));
            if (stalled) begin
                chk("stall_valid", 73'(out_valid), 73'(1));
                chk("stall_data", out_data, held);
            end
            if (out_valid && out_ready) begin
                npop++;
                if (q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL sb_extra_word actual=%0h required=no_word", out_data);
                end else begin
                    e = q.pop_front();
                    chk("sb_data", out_data, e);
                end
            end
            if (in_valid && in_ready) q.push_back(in_data);
            stalled = out_valid && !out_ready;
            held    = out_data;
        end
    endtask

    task automatic finish_cycle();
        sb_cycle();
        @(posedge clk); #1;
    endtask

    task automatic run_rows(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            rst = tbl[i].rst; in_valid = tbl[i].iv; in_data = tbl[i].d; out_ready = tbl[i].ordy;
            @(negedge clk);
            chk($sformatf("r%0d_in_ready", i), 73'(in_ready), 73'(tbl[i].e_ir));
            chk($sformatf("r%0d_wr_en", i), 73'(ram_wr_en), 73'(tbl[i].e_wr));
            chk($sformatf("r%0d_rd_en", i), 73'(ram_rd_en), 73'(tbl[i].e_rd));
            chk($sformatf("r%0d_out_valid", i), 73'(out_valid), 73'(tbl[i].e_ov));
            chk($sformatf("r%0d_occ", i), 73'(occ_count), 73'(tbl[i].e_occ));
            if (tbl[i].e_wr) chk($sformatf("r%0d_wr_addr", i), 73'(ram_wr_addr), 73'(tbl[i].e_wa));
            if (tbl[i].e_rd) chk($sformatf("r%0d_rd_addr", i), 73'(ram_rd_addr), 73'(tbl[i].e_ra));
            if (tbl[i].e_ov) chk($sformatf("r%0d_out_data", i), out_data, tbl[i].e_data);
            finish_cycle();
        end
    endtask

    initial begin
        int           sent, p0, first, last, n3;
        logic [95:0]  rnd;

        // Fill with backpressure, then a pop against a full RAM.
        tbl.push_back(mk(1, 1, 'hFF, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 'hA0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 'hA1, 0, 1, 1, 1, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 'hA2, 0, 1, 1, 2, 1, 1, 0, 0, 2));
        tbl.push_back(mk(0, 1, 'hA3, 0, 1, 1, 3, 1, 2, 0, 0, 3));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 'hA0, 4));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 'hA0, 4));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 'hA0, 4));
        tbl.push_back(mk(0, 1, 'hA4, 0, 1, 1, 0, 0, 0, 1, 'hA0, 4));
        tbl.push_back(mk(0, 1, 'hA5, 0, 1, 1, 1, 0, 0, 1, 'hA0, 5));
        tbl.push_back(mk(0, 1, 'hA6, 0, 1, 1, 2, 0, 0, 1, 'hA0, 6));
        tbl.push_back(mk(0, 1, 'hA7, 0, 0, 0, 0, 0, 0, 1, 'hA0, 7));
        tbl.push_back(mk(0, 1, 'hA7, 1, 0, 0, 0, 1, 3, 1, 'hA0, 7));
        tbl.push_back(mk(0, 1, 'hA7, 0, 1, 1, 3, 0, 0, 1, 'hA1, 6));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'hA1, 7));
        // Reset with two reads in flight, then single-word latency from address 0.
        tbl.push_back(mk(1, 1, 'hB0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 'hB0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 'hB1, 0, 1, 1, 1, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 'hB2, 0, 1, 1, 2, 1, 1, 0, 0, 2));
        tbl.push_back(mk(0, 1, 'hB3, 0, 1, 1, 3, 1, 2, 0, 0, 3));
        tbl.push_back(mk(0, 1, 'hB4, 0, 1, 1, 0, 0, 0, 1, 'hB0, 4));
        tbl.push_back(mk(0, 1, 'hB5, 1, 1, 1, 1, 1, 3, 1, 'hB0, 5));
        tbl.push_back(mk(0, 1, 'hB6, 1, 1, 1, 2, 1, 0, 1, 'hB1, 5));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'hB2, 5));
        tbl.push_back(mk(0, 1, 'h1_2345, 1, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 'h1_2345, 1));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        @(posedge clk); #1;
        run_rows(0, 14);

        for (int i = 0; i < 40 && q.size() != 0; i++) begin
            rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
            @(negedge clk);
            finish_cycle();
        end
        chk("drain_empty", 73'(q.size()), 73'(0));

        run_rows(15, 29);

        // Streaming: 20 words at one per clock in and out.
        sent = 0; first = -1; last = -1; n3 = 0;
        for (int c = 0; c < 80 && n3 < 20; c++) begin
            in_valid = (sent < 20); in_data = 73'(32'h300 + 32'(sent)); out_ready = 1'b1;
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (first < 0) first = c;
                last = c;
                n3++;
            end
            if (in_valid && in_ready) sent++;
            finish_cycle();
        end
        chk("t3_pops", 73'(n3), 73'(20));
        chk("t3_first_out", 73'(first), 73'(4));
        chk("t3_contiguous", 73'(last - first), 73'(19));

        // Random valid/ready over 1000 words.
        sent = 0; p0 = npop;
        for (int c = 0; c < 20000 && (npop - p0) < 1000; c++) begin
            rnd = {$urandom, $urandom, $urandom};
            in_valid  = (sent < 1000) && ($urandom_range(0, 1) == 1);
            in_data   = rnd[72:0];
            out_ready = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            chk("t4_capacity", 73'(q.size() <= 7), 73'(1));
            if (in_valid && in_ready) sent++;
            finish_cycle();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("t4_words", 73'(npop - p0), 73'(1000));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
